alu_shifter_stage: RTL and testbench
====================================

// Module: alu_shifter_stage
// PURPOSE
//  Execute-stage operand shifter sitting directly upstream of the ALU. Takes decoded
//  operands, applies the ARM barrel-shift to operand_b, registers result + shifter carry
//  and hands {operand_a, operand_b, alu_control} to the ALU via valid/ready.
//  One register stage plus a one-entry skid buffer so in_ready is fully registered.
// PARAMETERS
//  DATA_WIDTH  32  operand width (only 32 supported; shift rules below assume it)
//  CTRL_WIDTH  4   width of alu_control passed through to the ALU
//  AMT_WIDTH   8   shift-amount width (register-specified shifts use Rs[7:0])
// PORTS
//  clk            in   1           rising-edge clock
//  rst_n          in   1           synchronous reset, active-low
//  in_valid       in   1           upstream presents a transaction
//  in_ready       out  1           stage can accept (registered)
//  in_operand_a   in   DATA_WIDTH  first ALU operand, passed through unshifted
//  in_operand_b   in   DATA_WIDTH  value to shift
//  in_shift_type  in   2           00 LSL, 01 LSR, 10 ASR, 11 ROR
//  in_shift_amt   in   AMT_WIDTH   shift amount
//  in_shift_imm   in   1           1 = immediate encoding (amt[4:0] only, #0 special)
//  in_carry       in   1           current CPSR C flag
//  in_alu_control in   CTRL_WIDTH  ALU opcode, passed through
//  out_valid      out  1           ALU-side transaction valid
//  out_ready      in   1           ALU side accepts
//  operand_a      out  DATA_WIDTH  to ALU operand_a
//  operand_b      out  DATA_WIDTH  shifted value, to ALU operand_b
//  alu_control    out  CTRL_WIDTH  to ALU alu_control
//  shift_carry    out  1           shifter carry-out for logical-op C flag
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): out_valid=0, in_ready=1, operand_a/b=0, alu_control=0,
//   shift_carry=0, skid empty. Reset mid-transfer drops all held transactions.
//  Transfer: in on in_valid&in_ready; out on out_valid&out_ready. Latency 1 cycle.
//  States: EMPTY (out_valid=0) / ONE (output reg full) / FULL (output+skid full).
//   EMPTY: in xfer -> ONE.  ONE: in&out -> ONE; in only -> FULL; out only -> EMPTY.
//   FULL: in_ready=0; out xfer -> skid moves to output, ONE. Order strictly preserved.
//  Output regs hold stable while out_valid&!out_ready. Throughput 1/cycle when ready.
//  Effective amount n: imm ? amt[4:0] : amt (8 bit). x=in_operand_b, c=in_carry.
//  LSL: n=0 ->x,c; 1..31 ->x<<n, x[32-n]; 32 ->0, x[0]; >32 ->0, 0.
//  LSR: imm n=0 means 32. n=0 ->x,c; 1..31 ->x>>n, x[n-1]; 32 ->0, x[31]; >32 ->0, 0.
//  ASR: imm n=0 means 32. n=0 ->x,c; 1..31 ->arith x>>n, x[n-1]; >=32 ->{32{x[31]}}, x[31].
//  ROR: reg n=0 ->x,c; reg n!=0 & n[4:0]=0 ->x, x[31]; else rotate right n[4:0], x[n[4:0]-1].
//  ROR imm n=0: see CONFIGURATION.
// CONFIGURATION
//  SHIFT_RRX_EN defined: ROR imm #0 = RRX -> {c, x[31:1]}, carry x[0].
//  SHIFT_RRX_EN undefined: ROR imm #0 treated as no shift -> x, carry c.
// TESTING
//  LSL imm #4, b=0x0000_00F1 -> operand_b=0x0000_0F10, shift_carry=0, out_valid 1 cycle later.
//  LSR imm #0, b=0x8000_0001 -> operand_b=0, carry=1; ASR reg 40, b=0x8000_0000 -> 0xFFFF_FFFF, carry=1.
//  ROR reg 32, b=0x8000_0001, c=0 -> 0x8000_0001, carry=1; ROR imm #0, c=1, b=0x3
//   -> RRX_EN: 0x8000_0001, carry=1; else 0x0000_0003, carry=1.
//  Backpressure: out_ready=0, send 3 txns a=23,42,7 -> 2 accepted, in_ready=0; release -> 23,42,7 in order.
//  Streaming out_ready=1, 10 back-to-back txns -> 10 outputs on consecutive cycles, in_ready stays 1.
//  rst_n=0 while FULL -> next cycle out_valid=0, in_ready=1, all outputs 0; no stale txn emerges.

Source files
------------

// File: rtl/alu_shifter_stage.sv
// rtl/alu_shifter_stage.sv - ARM barrel shifter on operand_b with registered output stage and skid buffer.
// Optional macro SHIFT_RRX_EN: ROR immediate #0 performs RRX instead of passing the operand through.
module alu_shifter_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int AMT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_operand_a,
    input  logic [DATA_WIDTH-1:0] in_operand_b,
    input  logic [1:0]            in_shift_type,
    input  logic [AMT_WIDTH-1:0]  in_shift_amt,
    input  logic                  in_shift_imm,
    input  logic                  in_carry,
    input  logic [CTRL_WIDTH-1:0] in_alu_control,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] operand_a,
    output logic [DATA_WIDTH-1:0] operand_b,
    output logic [CTRL_WIDTH-1:0] alu_control,
    output logic                  shift_carry
);
    localparam int PW = 2 * DATA_WIDTH + CTRL_WIDTH + 1;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state, state_next;
    logic            in_ready_q, out_valid_q;
    logic            in_fire, out_fire;
    logic [PW-1:0]   in_pkt, out_pkt, skid_pkt;

    logic [DATA_WIDTH-1:0] x, sh_b;
    logic                  sh_c;
    logic [AMT_WIDTH-1:0]  n;
    logic [4:0]            n5;
    logic [8:0]            m;

    assign x = in_operand_b;

    // n is the effective amount; m additionally maps immediate #0 to 32 for LSR/ASR.
    always_comb begin
        n5   = in_shift_amt[4:0];
        n    = in_shift_imm ? {{(AMT_WIDTH-5){1'b0}}, n5} : in_shift_amt;
        m    = (in_shift_imm && n5 == 5'd0) ? 9'd32 : {1'b0, n};
        sh_b = x;
        sh_c = in_carry;
        case (in_shift_type)
            2'b00: begin
                if (n == 8'd0) begin
                    sh_b = x;
                end else if (n < 8'd32) begin
                    sh_b = x << n5;
                    sh_c = x[5'd0 - n5];
                end else if (n == 8'd32) begin
                    sh_b = '0;
                    sh_c = x[0];
                end else begin
                    sh_b = '0;
                    sh_c = 1'b0;
                end
            end
            2'b01: begin
                if (m == 9'd0) begin
                    sh_b = x;
                end else if (m < 9'd32) begin
                    sh_b = x >> m[4:0];
                    sh_c = x[m[4:0] - 5'd1];
                end else if (m == 9'd32) begin
                    sh_b = '0;
                    sh_c = x[31];
                end else begin
                    sh_b = '0;
                    sh_c = 1'b0;
                end
            end
            2'b10: begin
                if (m == 9'd0) begin
                    sh_b = x;
                end else if (m < 9'd32) begin
                    sh_b = $unsigned($signed(x) >>> m[4:0]);
                    sh_c = x[m[4:0] - 5'd1];
                end else begin
                    sh_b = {DATA_WIDTH{x[31]}};
                    sh_c = x[31];
                end
            end
            default: begin
                if (in_shift_imm && n5 == 5'd0) begin
`ifdef SHIFT_RRX_EN
                    sh_b = {in_carry, x[31:1]};
                    sh_c = x[0];
`else
                    sh_b = x;
`endif
                end else if (!in_shift_imm && n == 8'd0) begin
                    sh_b = x;
                end else if (n5 == 5'd0) begin
                    sh_b = x;
                    sh_c = x[31];
                end else begin
                    sh_b = (x >> n5) | (x << (5'd0 - n5));
                    sh_c = x[n5 - 5'd1];
                end
            end
        endcase
    end

    assign in_pkt      = {in_operand_a, sh_b, in_alu_control, sh_c};
    assign in_fire     = in_valid & in_ready_q;
    assign out_fire    = out_valid_q & out_ready;
    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign {operand_a, operand_b, alu_control, shift_carry} = out_pkt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (in_fire) state_next = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_next = FULL;
                else if (!in_fire && out_fire) state_next = EMPTY;
            end
            FULL:    if (out_fire) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake flags are registered copies of the next state so in_ready has no path from out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_pkt     <= '0;
            skid_pkt    <= '0;
        end else begin
            in_ready_q  <= (state_next != FULL);
            out_valid_q <= (state_next != EMPTY);
            case (state)
                EMPTY: if (in_fire) out_pkt <= in_pkt;
                ONE: begin
                    if (in_fire && out_fire) out_pkt  <= in_pkt;
                    else if (in_fire)        skid_pkt <= in_pkt;
                end
                FULL:  if (out_fire) out_pkt <= skid_pkt;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_shifter_stage.sv
// tb/tb_alu_shifter_stage.sv - randomized scoreboard bench for alu_shifter_stage with directed vectors.
module tb_alu_shifter_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_shift_imm, in_carry;
    logic [31:0] in_operand_a, in_operand_b, operand_a, operand_b;
    logic [1:0]  in_shift_type;
    logic [7:0]  in_shift_amt;
    logic [3:0]  in_alu_control, alu_control;
    logic        out_valid, out_ready, shift_carry;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_shifter_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_operand_a(in_operand_a), .in_operand_b(in_operand_b),
        .in_shift_type(in_shift_type), .in_shift_amt(in_shift_amt),
        .in_shift_imm(in_shift_imm), .in_carry(in_carry), .in_alu_control(in_alu_control),
        .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a),
        .operand_b(operand_b), .alu_control(alu_control), .shift_carry(shift_carry)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the shift is applied one bit at a time, carry = last bit shifted out.
    function automatic void ref_shift(input logic [31:0] x, input logic [1:0] t, input logic [7:0] amt,
                                      input logic imm, input logic c,
                                      output logic [31:0] r, output logic co);
        int cnt;
        cnt = imm ? int'(amt[4:0]) : int'(amt);
        r = x;
        co = c;
        if (t == 2'b11 && imm && cnt == 0) begin
`ifdef SHIFT_RRX_EN
            r = {c, x[31:1]};
            co = x[0];
`endif
        end else begin
            if ((t == 2'b01 || t == 2'b10) && imm && cnt == 0) cnt = 32;
            for (int i = 0; i < cnt; i++) begin
                case (t)
                    2'b00:   begin co = r[31]; r = r << 1; end
                    2'b01:   begin co = r[0];  r = r >> 1; end
                    2'b10:   begin co = r[0];  r = {r[31], r[31:1]}; end
                    default: begin co = r[0];  r = {r[0], r[31:1]}; end
                endcase
            end
        end
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        c;
    } exp_t;

    exp_t        q[$];
    logic [31:0] got_a[$];
    int          fire_cycles[$];
    bit          was_reset = 0;
    bit          log_en = 0;
    int          ir_low = 0;
    int          cyc = 0;

    // Compare process: outputs must match the head of the expected queue every cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] rb;
        logic        rc;
        if (was_reset) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
            if (q.size() > 0) begin
                chk("operand_a", operand_a, q[0].a);
                chk("operand_b", operand_b, q[0].b);
                chk("alu_control", {28'b0, alu_control}, {28'b0, q[0].ctrl});
                chk("shift_carry", {31'b0, shift_carry}, {31'b0, q[0].c});
            end
            if (log_en && !in_ready) ir_low++;
        end
        if (!rst_n) begin
            q.delete();
            was_reset = 1;
        end else if (was_reset) begin
            if (out_valid && out_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                got_a.push_back(operand_a);
                if (log_en) fire_cycles.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                ref_shift(in_operand_b, in_shift_type, in_shift_amt, in_shift_imm, in_carry, rb, rc);
                e.a = in_operand_a; e.b = rb; e.ctrl = in_alu_control; e.c = rc;
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                          input logic [7:0] amt, input logic imm, input logic c, input logic [3:0] ctrl);
        in_operand_a = a; in_operand_b = b; in_shift_type = t;
        in_shift_amt = amt; in_shift_imm = imm; in_carry = c; in_alu_control = ctrl;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                        input logic [7:0] amt, input logic imm, input logic c, input logic [3:0] ctrl);
        logic acc;
        acc = 1'b0;
        set_in(a, b, t, amt, imm, c, ctrl);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    typedef struct {
        logic [31:0] b;
        logic [1:0]  t;
        logic [7:0]  amt;
        logic        imm;
        logic        c;
        logic [31:0] eb;
        logic        ec;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [31:0] rb;
        logic        rc;
        logic [7:0]  amt;
        vecs[0] = '{32'h0000_00F1, 2'b00, 8'd4,  1'b1, 1'b0, 32'h0000_0F10, 1'b0};
        vecs[1] = '{32'h8000_0001, 2'b01, 8'd0,  1'b1, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'h8000_0000, 2'b10, 8'd40, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{32'h8000_0001, 2'b11, 8'd32, 1'b0, 1'b0, 32'h8000_0001, 1'b1};
`ifdef SHIFT_RRX_EN
        vecs[4] = '{32'h0000_0003, 2'b11, 8'd0,  1'b1, 1'b1, 32'h8000_0001, 1'b1};
`else
        vecs[4] = '{32'h0000_0003, 2'b11, 8'd0,  1'b1, 1'b1, 32'h0000_0003, 1'b1};
`endif
        vecs[5] = '{32'h0000_0001, 2'b00, 8'd32, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 2'b00, 8'd33, 1'b0, 1'b1, 32'h0000_0000, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_operand_b", operand_b, 32'd0);
        chk("reset_carry", {31'b0, shift_carry}, 32'd0);

        // Pin the model itself, then drive the same vectors through the DUT.
        for (int i = 0; i < 7; i++) begin
            ref_shift(vecs[i].b, vecs[i].t, vecs[i].amt, vecs[i].imm, vecs[i].c, rb, rc);
            chk($sformatf("model_b[%0d]", i), rb, vecs[i].eb);
            chk($sformatf("model_c[%0d]", i), {31'b0, rc}, {31'b0, vecs[i].ec});
        end
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(32'h100 + i, vecs[i].b, vecs[i].t, vecs[i].amt, vecs[i].imm, vecs[i].c, 4'(i));
            chk($sformatf("vec_valid[%0d]", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec_b[%0d]", i), operand_b, vecs[i].eb);
            chk($sformatf("vec_c[%0d]", i), {31'b0, shift_carry}, {31'b0, vecs[i].ec});
            tick();
        end

        // Backpressure: two accepted, third stalls, then all emerge in order.
        drain();
        got_a.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_in(23, 32'h1, 2'b00, 8'd1, 1'b1, 1'b0, 4'h1); tick();
        set_in(42, 32'h2, 2'b01, 8'd1, 1'b1, 1'b0, 4'h2); tick();
        set_in(7,  32'h3, 2'b10, 8'd1, 1'b1, 1'b0, 4'h3); tick();
        repeat (2) tick();
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_a", operand_a, 32'd23);
        out_ready = 1'b1;
        begin
            logic acc;
            acc = 1'b0;
            for (int k = 0; k < 20 && !acc; k++) begin
                @(negedge clk);
                acc = in_ready;
                tick();
            end
            if (!acc) chk("bp_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_count", got_a.size(), 32'd3);
        if (got_a.size() == 3) begin
            chk("bp_order0", got_a[0], 32'd23);
            chk("bp_order1", got_a[1], 32'd42);
            chk("bp_order2", got_a[2], 32'd7);
        end

        // Streaming at full rate.
        drain();
        fire_cycles.delete();
        ir_low = 0;
        log_en = 1;
        for (int i = 0; i < 10; i++) send(i, 32'hA5A5_0000 + i, 2'(i), 8'(i * 3), 1'b0, 1'b1, 4'(i));
        repeat (3) tick();
        log_en = 0;
        chk("stream_count", fire_cycles.size(), 32'd10);
        if (fire_cycles.size() == 10) chk("stream_span", fire_cycles[9] - fire_cycles[0], 32'd9);
        chk("stream_in_ready_low", ir_low, 32'd0);

        // Reset while FULL drops everything.
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_in(32'h55, 32'hFF, 2'b00, 8'd2, 1'b0, 1'b1, 4'hF); tick();
        set_in(32'h66, 32'hF0, 2'b11, 8'd4, 1'b1, 1'b1, 4'hE); tick();
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_operand_a", operand_a, 32'd0);
        chk("rst_operand_b", operand_b, 32'd0);
        chk("rst_alu_control", {28'b0, alu_control}, 32'd0);
        chk("rst_carry", {31'b0, shift_carry}, 32'd0);
        got_a.delete();
        out_ready = 1'b1;
        repeat (5) tick();
        chk("rst_no_stale", got_a.size(), 32'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 2000; i++) begin
            case ($urandom % 6)
                0: amt = 8'd0;
                1: amt = 8'd32;
                2: amt = 8'd31;
                3: amt = 8'd33;
                4: amt = 8'd1;
                default: amt = 8'($urandom);
            endcase
            set_in($urandom, $urandom, 2'($urandom), amt, 1'($urandom), 1'($urandom), 4'($urandom));
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
